scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 142 ++++++++++++++
 tb/tb_scan_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Turntable scan sequencer: for each angular position it settles, captures one
// camera frame between two vsync edges, waits for processing, then steps the table.
module scan_sequencer #(
  parameter int unsigned STEPS_PER_REV = 200,
  parameter int unsigned SETTLE_CYCLES = 1000000,
  parameter int unsigned STEP_PULSE    = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       vsync,
  input  logic       frame_done,
  output logic       latch,
  output logic       step_out,
  output logic       dir_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] step_index
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, ARM, CAPTURE, PROCESS, STEP_HI, STEP_LO, DONE
  } state_t;

  localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);
  localparam logic [31:0] PULSE_LAST  = 32'(STEP_PULSE - 1);
  localparam logic [7:0]  LAST_INDEX  = 8'(STEPS_PER_REV - 1);

  state_t      state;
  logic [31:0] count;
  logic        start_q;
  logic        vsync_q;
  logic        primed;
  logic        start_rise;
  logic        vsync_rise;

  // primed stays low for the first cycle after reset so a start level held
  // through reset release is never mistaken for a fresh request.
  assign start_rise = primed & start & ~start_q;
  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      start_q    <= 1'b0;
      vsync_q    <= 1'b0;
      primed     <= 1'b0;
      latch      <= 1'b0;
      step_out   <= 1'b0;
      dir_out    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_index <= '0;
    end else begin
      start_q <= start;
      vsync_q <= vsync;
      primed  <= 1'b1;
      dir_out <= 1'b1;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        count      <= '0;
        latch      <= 1'b0;
        step_out   <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
        step_index <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise && !abort) begin
              state      <= SETTLE;
              busy       <= 1'b1;
              step_index <= '0;
              count      <= '0;
            end
          end
          SETTLE: begin
            if (count == SETTLE_LAST) begin
              state <= ARM;
              count <= '0;
            end else begin
              count <= count + 32'd1;
            end
          end
          ARM: begin
            if (vsync_rise) begin
              state <= CAPTURE;
              latch <= 1'b1;
            end
          end
          CAPTURE: begin
            if (vsync_rise) begin
              state <= PROCESS;
              latch <= 1'b0;
            end
          end
          PROCESS: begin
            if (frame_done) begin
              if (step_index == LAST_INDEX) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= STEP_HI;
                step_out <= 1'b1;
                count    <= '0;
              end
            end
          end
          STEP_HI: begin
            if (count == PULSE_LAST) begin
              state    <= STEP_LO;
              step_out <= 1'b0;
              count    <= '0;
            end else begin
              count <= count + 32'd1;
            end
          end
          STEP_LO: begin
            if (count == PULSE_LAST) begin
              state      <= SETTLE;
              step_index <= step_index + 8'd1;
              count      <= '0;
            end else begin
              count <= count + 32'd1;
            end
          end
          DONE: begin
            state      <= IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            step_index <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed scenarios plus randomized scans, checked
// against an event-timeline model of the scan sequence.
module tb_scan_sequencer;
  localparam int SPR = 3;
  localparam int SET = 4;
  localparam int PUL = 2;

  logic       clk = 1'b0;
  logic       reset_n, start, start1, abort, vsync, frame_done;
  logic       latch, step_out, dir_out, busy, done;
  logic [7:0] step_index;
  logic       latch1, step1, dir1, busy1, done1;
  logic [7:0] idx1;

  always #5 clk = ~clk;

  scan_sequencer #(.STEPS_PER_REV(3), .SETTLE_CYCLES(4), .STEP_PULSE(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .vsync(vsync),
    .frame_done(frame_done), .latch(latch), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .done(done), .step_index(step_index)
  );

  scan_sequencer #(.STEPS_PER_REV(1), .SETTLE_CYCLES(0), .STEP_PULSE(2)) u_one (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .vsync(vsync),
    .frame_done(frame_done), .latch(latch1), .step_out(step1), .dir_out(dir1),
    .busy(busy1), .done(done1), .step_index(idx1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- vsync generator and frame_done responder ----------------
  int vs_period = 20;
  int vs_cnt    = 0;
  int fd_delay  = 5;
  int fd_timer  = 0;
  bit fd_noise  = 1'b0;
  bit fd_force  = 1'b0;
  bit lat_seen  = 1'b0;

  initial begin
    vsync      = 1'b0;
    frame_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      vs_cnt = (vs_cnt + 1) % vs_period;
      vsync  = (vs_cnt < vs_period / 2);
      frame_done = 1'b0;
      if (fd_timer > 0) begin
        fd_timer--;
        if (fd_timer == 0) frame_done = 1'b1;
      end
      if (lat_seen && !(latch || latch1)) fd_timer = fd_delay;
      lat_seen = latch || latch1;
      if (fd_force) begin
        frame_done = 1'b1;
        fd_force   = 1'b0;
      end
      if (fd_noise && $urandom_range(0, 15) == 0) frame_done = 1'b1;
    end
  end

  // ---------------- reference model and observers ----------------
  // Sample n is taken at the falling edge after rising edge n: inputs seen here
  // are consumed at rising edge n+1, so every event scheduled below lands at n+1 or later.
  int n = 0;
  bit m_active = 0, m_win = 0, m_wait = 0;
  int m_idx = 0, arm_at = -1, hi_from = -100, inc_at = -1, done_at = -1, end_at = -1;
  bit p_start = 0, p_rst = 0, p_vs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  int n_latch = 0, n_step = 0, n_done = 0, lat_run = 0, step_run = 0;
  bit lat_cut = 0, step_cut = 0, p_latch = 0, p_step = 0, p_done = 0;
  int n1_latch = 0, n1_step = 0, n1_done = 0, lat1_run = 0;
  bit p_latch1 = 0, p_step1 = 0, p_done1 = 0;

  task automatic model_clear();
    m_active = 0; m_win = 0; m_wait = 0; m_idx = 0;
    arm_at = -1; hi_from = -100; inc_at = -1; done_at = -1; end_at = -1;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    n++;
    if (n == inc_at) m_idx++;
    if (n == end_at) begin
      m_active = 0;
      m_idx    = 0;
    end
    check("busy",       32'(busy),       32'(m_active));
    check("latch",      32'(latch),      32'(m_win));
    check("step_out",   32'(step_out),   32'(n >= hi_from && n < hi_from + PUL));
    check("done",       32'(done),       32'(n == done_at));
    check("step_index", 32'(step_index), 32'(m_idx));
    check("dir_out",    32'(dir_out),    32'd1);

    if (latch && !p_latch) begin
      n_latch++;
      lat_run = 0;
      lat_cut = 0;
      exp_w = 8'hFF;
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      check("win_index", 32'(step_index), 32'(exp_w));
    end
    if (latch) lat_run++;
    if (!latch && p_latch && !lat_cut) check("latch_len", 32'(lat_run), 32'(vs_period));
    if (step_out && !p_step) begin
      n_step++;
      step_run = 0;
      step_cut = 0;
    end
    if (step_out) step_run++;
    if (!step_out && p_step && !step_cut) check("step_len", 32'(step_run), 32'(PUL));
    if (done && !p_done) n_done++;
    if ((abort || !reset_n) && latch) lat_cut = 1;
    if ((abort || !reset_n) && step_out) step_cut = 1;

    if (latch1 && !p_latch1) begin
      n1_latch++;
      lat1_run = 0;
    end
    if (latch1) lat1_run++;
    if (!latch1 && p_latch1) check("one_latch_len", 32'(lat1_run), 32'(vs_period));
    if (step1 && !p_step1) n1_step++;
    if (done1 && !p_done1) n1_done++;

    if (!reset_n) begin
      model_clear();
    end else if (abort && m_active) begin
      model_clear();
    end else begin
      if (start && !p_start && p_rst && !abort && !m_active) begin
        m_active = 1;
        m_idx    = 0;
        arm_at   = n + 1 + SET;
        exp_q.delete();
        for (int i = 0; i < SPR; i++) exp_q.push_back(8'(i));
      end
      if (frame_done && m_wait) begin
        m_wait = 0;
        if (m_idx == SPR - 1) begin
          done_at = n + 1;
          end_at  = n + 2;
        end else begin
          hi_from = n + 1;
          inc_at  = n + 1 + 2 * PUL;
          arm_at  = inc_at + SET;
        end
      end
      if (vsync && !p_vs && m_active) begin
        if (m_win) begin
          m_win  = 0;
          m_wait = 1;
        end else if (arm_at >= 0 && n >= arm_at) begin
          m_win  = 1;
          arm_at = -1;
        end
      end
    end
    p_start = start; p_rst = reset_n; p_vs = vsync;
    p_latch = latch; p_step = step_out; p_done = done;
    p_latch1 = latch1; p_step1 = step1; p_done1 = done1;
  end

  // ---------------- driver tasks ----------------
  task automatic step_cycles(input int c);
    repeat (c) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return latch;
      1:       return step_out;
      2:       return busy;
      default: return busy1;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic level, input int max, input string tag);
    for (int i = 0; i < max && sel_sig(which) !== level; i++) step_cycles(1);
    check(tag, 32'(sel_sig(which)), 32'(level));
  endtask

  task automatic pulse_start();
    start = 1'b0;
    step_cycles(1);
    start = 1'b1;
    step_cycles(1);
  endtask

  int bl, bs, bd;

  initial begin
    reset_n = 1'b0; start = 1'b1; start1 = 1'b0; abort = 1'b0;
    step_cycles(3);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_latch", 32'(latch),      32'd0);
    check("rst_step",  32'(step_out),   32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_index", 32'(step_index), 32'd0);
    check("rst_dir",   32'(dir_out),    32'd1);

    // start held high through reset release must not launch a scan
    reset_n = 1'b1;
    step_cycles(12);
    check("held_start_idle", 32'(busy), 32'd0);

    // full scan: vsync period 20, frame_done 5 cycles after each latch fall
    vs_period = 20; fd_delay = 5;
    bl = n_latch; bs = n_step; bd = n_done;
    pulse_start();
    check("scan_started", 32'(busy), 32'd1);
    wait_sig(2, 1'b0, 2000, "full_idle");
    check("full_windows", 32'(n_latch - bl), 32'd3);
    check("full_steps",   32'(n_step - bs),  32'd2);
    check("full_done",    32'(n_done - bd),  32'd1);
    check("full_index",   32'(step_index),   32'd0);

    // second start edge in CAPTURE and frame_done during SETTLE are ignored
    bl = n_latch; bs = n_step; bd = n_done;
    pulse_start();
    wait_sig(0, 1'b1, 200, "cap_wait");
    pulse_start();
    wait_sig(1, 1'b1, 300, "stephi_wait");
    wait_sig(1, 1'b0, 10, "steplo_wait");
    step_cycles(3);
    fd_force = 1'b1;
    wait_sig(2, 1'b0, 2000, "noise_idle");
    check("noise_windows", 32'(n_latch - bl), 32'd3);
    check("noise_steps",   32'(n_step - bs),  32'd2);
    check("noise_done",    32'(n_done - bd),  32'd1);

    // abort during STEP_HI
    bd = n_done;
    pulse_start();
    wait_sig(1, 1'b1, 300, "abort_wait");
    abort = 1'b1;
    step_cycles(1);
    abort = 1'b0;
    check("abort_step",  32'(step_out),   32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_index", 32'(step_index), 32'd0);
    step_cycles(10);
    check("abort_nodone", 32'(n_done - bd), 32'd0);

    // randomized scans with noise on start, abort and frame_done
    for (int it = 0; it < 25; it++) begin
      vs_period = $urandom_range(8, 24);
      fd_delay  = $urandom_range(1, 8);
      fd_noise  = 1'($urandom_range(0, 1));
      pulse_start();
      for (int c = 0; c < 1200 && busy; c++) begin
        abort = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 19) == 0) start = ~start;
        step_cycles(1);
      end
      abort = 1'b1;
      step_cycles(1);
      abort = 1'b0;
      start = 1'b0;
      step_cycles(2);
      check("rand_idle", 32'(busy), 32'd0);
    end
    fd_noise = 1'b0;

    // single-position scan on the second instance
    vs_period = 16; fd_delay = 3;
    step_cycles(30);
    bl = n1_latch; bs = n1_step; bd = n1_done;
    start1 = 1'b1;
    step_cycles(2);
    check("one_busy", 32'(busy1), 32'd1);
    wait_sig(3, 1'b0, 500, "one_idle");
    check("one_windows", 32'(n1_latch - bl), 32'd1);
    check("one_steps",   32'(n1_step - bs),  32'd0);
    check("one_done",    32'(n1_done - bd),  32'd1);
    check("one_index",   32'(idx1),          32'd0);
    check("one_dir",     32'(dir1),          32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
